// File: rtl/bp_ctrl.sv
// bp_ctrl: owns the branch predictor table write port and sequences the
// fetch PC. After reset it clears every table entry, then steers fetch from
// predictor lookups and ALU mispredict redirects. Mispredict updates are
// buffered in a small FIFO and drained into the table under tbl_ready_i.
module bp_ctrl #(
  parameter int          ENTRIES  = 16,
  parameter int          IDX_W    = 4,
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             stall_i,
  input  logic             bp_pred_i,
  input  logic             bp_taken_i,
  input  logic [31:0]      bp_pred_pc_i,
  input  logic             alu_valid_i,
  input  logic             alu_error_i,
  input  logic             alu_jumps_i,
  input  logic [31:0]      alu_branch_pc_i,
  input  logic [31:0]      alu_target_pc_i,
  input  logic             tbl_ready_i,
  output logic [31:0]      pc_o,
  output logic             flush_o,
  output logic             busy_o,
  output logic             tbl_we_o,
  output logic             tbl_clr_o,
  output logic [IDX_W-1:0] tbl_idx_o,
  output logic             tbl_jumps_o,
  output logic [31:0]      tbl_branch_pc_o,
  output logic [31:0]      tbl_target_pc_o,
  output logic             upd_drop_o
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_sweep_idx;
  logic [IDX_W-1:0] w_sweep_nxt;
  logic [31:0]      r_pc;
  logic [31:0]      w_pc_nxt;

  // Update FIFO storage and bookkeeping
  logic             r_q_jumps [QDEPTH];
  logic [31:0]      r_q_bpc   [QDEPTH];
  logic [31:0]      r_q_tpc   [QDEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_err;
  logic             w_active;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic [31:0]      w_redir_pc;

  assign w_err      = alu_valid_i & alu_error_i;
  assign w_active   = (r_state != ST_INIT);
  assign w_empty    = (r_count == {CNT_W{1'b0}});
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = w_active & ~w_empty & tbl_ready_i;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_active & w_err & (~w_full | w_pop);
  assign w_drop     = w_active & w_err & w_full & ~w_pop;
  assign w_redir_pc = alu_jumps_i ? alu_target_pc_i : (alu_branch_pc_i + 32'd4);

  // State, sweep index and fetch PC registers
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state     <= ST_INIT;
      r_sweep_idx <= {IDX_W{1'b0}};
      r_pc        <= RESET_PC;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
      r_pc        <= w_pc_nxt;
    end
  end

  // Next-state, next sweep index and next fetch PC selection
  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_idx;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_INIT: begin
        w_pc_nxt = RESET_PC;
        if (tbl_ready_i) begin
          if (r_sweep_idx == LAST_IDX) begin
            w_state_nxt = ST_RUN;
            w_sweep_nxt = {IDX_W{1'b0}};
          end else begin
            w_sweep_nxt = r_sweep_idx + IDX_W'(1);
          end
        end else begin
          w_sweep_nxt = r_sweep_idx;
        end
      end
      ST_RUN: begin
        if (w_err) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = ST_REDIR;
        end else if (stall_i) begin
          w_pc_nxt = r_pc;
        end else if (bp_pred_i && bp_taken_i) begin
          w_pc_nxt = bp_pred_pc_i;
        end else begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      ST_REDIR: begin
        // The corrected PC is held for the flush cycle unless re-redirected.
        if (w_err) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = ST_REDIR;
        end else begin
          w_pc_nxt    = r_pc;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_sweep_nxt = {IDX_W{1'b0}};
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  // Update FIFO: write on push, advance read pointer on pop
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_jumps[i] <= 1'b0;
        r_q_bpc[i]   <= 32'd0;
        r_q_tpc[i]   <= 32'd0;
      end
    end else begin
      if (w_push) begin
        r_q_jumps[r_wptr] <= alu_jumps_i;
        r_q_bpc[r_wptr]   <= alu_branch_pc_i;
        r_q_tpc[r_wptr]   <= alu_target_pc_i;
        r_wptr            <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Table write port: clear sweep during INIT, FIFO head otherwise
  always_comb begin
    tbl_we_o        = 1'b0;
    tbl_clr_o       = 1'b0;
    tbl_idx_o       = {IDX_W{1'b0}};
    tbl_jumps_o     = 1'b0;
    tbl_branch_pc_o = 32'd0;
    tbl_target_pc_o = 32'd0;
    if (r_state == ST_INIT) begin
      tbl_we_o  = 1'b1;
      tbl_clr_o = 1'b1;
      tbl_idx_o = r_sweep_idx;
    end else if (!w_empty) begin
      tbl_we_o        = 1'b1;
      tbl_idx_o       = r_q_bpc[r_rptr][IDX_W+1:2];
      tbl_jumps_o     = r_q_jumps[r_rptr];
      tbl_branch_pc_o = r_q_bpc[r_rptr];
      tbl_target_pc_o = r_q_tpc[r_rptr];
    end else begin
      tbl_we_o = 1'b0;
    end
  end

  assign pc_o       = r_pc;
  assign flush_o    = (r_state == ST_REDIR);
  assign busy_o     = (r_state == ST_INIT);
  // Drop must be visible in the same cycle as the rejected push.
  assign upd_drop_o = w_drop;

endmodule

// File: tb/tb_bp_ctrl.sv
// Scoreboard bench for bp_ctrl: expected table writes are queued when the
// stimulus is driven and compared when the DUT completes a write handshake.
module tb_bp_ctrl;

  localparam int IDX_W = 4;

  logic             clk_i = 1'b0;
  logic             rsn_i = 1'b0;
  logic             stall_i, bp_pred_i, bp_taken_i;
  logic [31:0]      bp_pred_pc_i;
  logic             alu_valid_i, alu_error_i, alu_jumps_i;
  logic [31:0]      alu_branch_pc_i, alu_target_pc_i;
  logic             tbl_ready_i;
  logic [31:0]      pc_o;
  logic             flush_o, busy_o, tbl_we_o, tbl_clr_o;
  logic [IDX_W-1:0] tbl_idx_o;
  logic             tbl_jumps_o;
  logic [31:0]      tbl_branch_pc_o, tbl_target_pc_o;
  logic             upd_drop_o;

  typedef struct {
    logic             clr;
    logic [IDX_W-1:0] idx;
    logic             jumps;
    logic [31:0]      bpc;
    logic [31:0]      tpc;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  bp_ctrl dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .stall_i(stall_i),
    .bp_pred_i(bp_pred_i), .bp_taken_i(bp_taken_i), .bp_pred_pc_i(bp_pred_pc_i),
    .alu_valid_i(alu_valid_i), .alu_error_i(alu_error_i), .alu_jumps_i(alu_jumps_i),
    .alu_branch_pc_i(alu_branch_pc_i), .alu_target_pc_i(alu_target_pc_i),
    .tbl_ready_i(tbl_ready_i), .pc_o(pc_o), .flush_o(flush_o), .busy_o(busy_o),
    .tbl_we_o(tbl_we_o), .tbl_clr_o(tbl_clr_o), .tbl_idx_o(tbl_idx_o),
    .tbl_jumps_o(tbl_jumps_o), .tbl_branch_pc_o(tbl_branch_pc_o),
    .tbl_target_pc_o(tbl_target_pc_o), .upd_drop_o(upd_drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Compare each accepted table write against the scoreboard head
  always @(negedge clk_i) begin
    if (rsn_i === 1'b1 && tbl_we_o === 1'b1 && tbl_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_write_bpc", tbl_branch_pc_o, 32'hDEAD_BEEF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_val("wr_clr",   tbl_clr_o,       e.clr);
        check_val("wr_idx",   tbl_idx_o,       e.idx);
        check_val("wr_jumps", tbl_jumps_o,     e.jumps);
        check_val("wr_bpc",   tbl_branch_pc_o, e.bpc);
        check_val("wr_tpc",   tbl_target_pc_o, e.tpc);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    stall_i = 1'b0; bp_pred_i = 1'b0; bp_taken_i = 1'b0; bp_pred_pc_i = 32'd0;
    alu_valid_i = 1'b0; alu_error_i = 1'b0; alu_jumps_i = 1'b0;
    alu_branch_pc_i = 32'd0; alu_target_pc_i = 32'd0;
  endtask

  task automatic push_clears();
    for (int i = 0; i < 16; i++) begin
      wr_t e;
      e.clr = 1'b1; e.idx = IDX_W'(i); e.jumps = 1'b0; e.bpc = 32'd0; e.tpc = 32'd0;
      exp_q.push_back(e);
    end
  endtask

  // Drive one mispredict; queue its expected write only when it should be kept
  task automatic drive_err(input logic j, input logic [31:0] bpc, input logic [31:0] tpc,
                           input logic expect_kept);
    alu_valid_i = 1'b1; alu_error_i = 1'b1; alu_jumps_i = j;
    alu_branch_pc_i = bpc; alu_target_pc_i = tpc;
    if (expect_kept) begin
      wr_t e;
      e.clr = 1'b0; e.idx = bpc[5:2]; e.jumps = j; e.bpc = bpc; e.tpc = tpc;
      exp_q.push_back(e);
    end
  endtask

  // Assert reset now, check reset outputs, then release after two edges
  task automatic apply_reset();
    exp_q.delete();
    rsn_i = 1'b0;
    idle();
    #1;
    check_val("rst_pc",    pc_o,       32'h0);
    check_val("rst_busy",  busy_o,     1'b1);
    check_val("rst_flush", flush_o,    1'b0);
    check_val("rst_drop",  upd_drop_o, 1'b0);
    check_val("rst_we",    tbl_we_o,   1'b1);
    check_val("rst_clr",   tbl_clr_o,  1'b1);
    check_val("rst_idx",   tbl_idx_o,  32'h0);
    push_clears();
    step();
    step();
    rsn_i = 1'b1;
  endtask

  task automatic sweep_full_ready();
    tbl_ready_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check_val("sweep_busy", busy_o, (k < 16) ? 1'b1 : 1'b0);
      check_val("sweep_pc",   pc_o,   32'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    tbl_ready_i = 1'b1;
    #2;

    // Sweep with ready held high, then sequential fetch
    apply_reset();
    sweep_full_ready();
    check_val("run_flush", flush_o, 1'b0);
    step(); check_val("seq_pc4",  pc_o, 32'h4);
    step(); check_val("seq_pc8",  pc_o, 32'h8);
    step(); check_val("seq_pc12", pc_o, 32'hC);

    // Sweep with ready toggling; ALU errors during INIT must be ignored
    apply_reset();
    drive_err(1'b1, 32'h0000_0040, 32'h0000_0500, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      tbl_ready_i = (k % 2 == 0);
      #1;
      if (k == 1) check_val("init_no_drop", upd_drop_o, 1'b0);
      step();
      if (k == 31) check_val("toggle_busy31", busy_o, 1'b1);
      check_val("toggle_pc", pc_o, 32'h0);
    end
    check_val("toggle_busy32", busy_o, 1'b0);
    idle();
    tbl_ready_i = 1'b1;

    // Predictor taken, stall hold, not-taken fall-through
    bp_pred_i = 1'b1; bp_taken_i = 1'b1; bp_pred_pc_i = 32'h200;
    step(); check_val("pred_taken", pc_o, 32'h200);
    stall_i = 1'b1;
    step(); check_val("pred_stall", pc_o, 32'h200);
    stall_i = 1'b0; bp_taken_i = 1'b0;
    step(); check_val("pred_nt", pc_o, 32'h204);
    bp_pred_i = 1'b0;
    step(); check_val("seq_after", pc_o, 32'h208);

    // Not-taken mispredict under stall
    stall_i = 1'b1;
    drive_err(1'b0, 32'h104, 32'h300, 1'b1);
    step();
    check_val("redir_pc",    pc_o,      32'h108);
    check_val("redir_flush", flush_o,   1'b1);
    check_val("upd_we",      tbl_we_o,  1'b1);
    check_val("upd_idx",     tbl_idx_o, 32'h1);
    idle();
    step();
    check_val("redir_hold",  pc_o,     32'h108);
    check_val("flush_off",   flush_o,  1'b0);
    check_val("upd_drained", tbl_we_o, 1'b0);
    step(); check_val("post_redir", pc_o, 32'h10C);

    // Taken mispredict followed by another error while in REDIR
    drive_err(1'b1, 32'h400, 32'h800, 1'b1);
    step(); check_val("taken_redir", pc_o, 32'h800);
    drive_err(1'b0, 32'h7FC, 32'h0, 1'b1);
    step();
    check_val("rerdir_pc",    pc_o,    32'h800);
    check_val("rerdir_flush", flush_o, 1'b1);
    idle();
    step(); check_val("rerdir_done", flush_o, 1'b0);

    // PC wraps modulo 2^32
    bp_pred_i = 1'b1; bp_taken_i = 1'b1; bp_pred_pc_i = 32'hFFFF_FFFC;
    step(); check_val("wrap_pre", pc_o, 32'hFFFF_FFFC);
    idle();
    step(); check_val("wrap_pc", pc_o, 32'h0);

    // Queue full: third error dropped, then push+pop at full
    tbl_ready_i = 1'b0;
    drive_err(1'b1, 32'h10, 32'h1000, 1'b1);
    #1; check_val("q_drop1", upd_drop_o, 1'b0);
    step();
    drive_err(1'b0, 32'h14, 32'h2000, 1'b1);
    #1; check_val("q_drop2", upd_drop_o, 1'b0);
    step();
    drive_err(1'b1, 32'h18, 32'h3000, 1'b0);
    #1;
    check_val("q_drop3",   upd_drop_o, 1'b1);
    check_val("q_headidx", tbl_idx_o,  32'h4);
    step();
    check_val("drop_redir", pc_o,    32'h3000);
    check_val("drop_flush", flush_o, 1'b1);
    tbl_ready_i = 1'b1;
    drive_err(1'b0, 32'h1C, 32'h4000, 1'b1);
    #1; check_val("q_pushpop_nodrop", upd_drop_o, 1'b0);
    step(); check_val("pushpop_pc", pc_o, 32'h20);
    idle();
    for (int k = 0; k < 4; k++) step();
    check_val("q_empty_we", tbl_we_o, 1'b0);
    check_val("sb_empty",   exp_q.size(), 32'h0);

    // Reset mid-drain clears the queue and restarts the sweep
    tbl_ready_i = 1'b0;
    drive_err(1'b0, 32'h20, 32'h0, 1'b1);
    step();
    drive_err(1'b0, 32'h24, 32'h0, 1'b1);
    step();
    idle();
    tbl_ready_i = 1'b1;
    step();
    apply_reset();
    sweep_full_ready();
    check_val("rst_q_cleared", tbl_we_o, 1'b0);
    step();
    step();
    check_val("rst_q_still_empty", tbl_we_o, 1'b0);
    check_val("sb_empty_end", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_ctrl.md
Name: bp_ctrl

Overview:
- Controller that owns the branch predictor table write port and sequences the fetch PC.
- After reset it sweeps the predictor table clear, one entry per cycle.
- In normal operation it generates the next fetch PC from predictor lookups and ALU mispredict redirects.
- Mispredict updates are buffered in a small queue and drained into the table under a ready handshake.

Parameters:
ENTRIES, 16, number of predictor table entries (power of two)
IDX_W, 4, log2(ENTRIES); table index = PC[IDX_W+1:2]
QDEPTH, 2, update queue depth (power of two, >=2)
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk_i  in  1  clock, rising edge
rsn_i  in  1  reset, asynchronous, active-low
stall_i  in  1  fetch stall; PC holds
bp_pred_i  in  1  predictor lookup hit for pc_o
bp_taken_i  in  1  predictor says taken
bp_pred_pc_i  in  32  predicted target
alu_valid_i  in  1  ALU resolved a control instruction this cycle
alu_error_i  in  1  resolution disagrees with prediction (qualified by alu_valid_i)
alu_jumps_i  in  1  actual outcome taken
alu_branch_pc_i  in  32  PC of resolved instruction
alu_target_pc_i  in  32  actual taken target
tbl_ready_i  in  1  table accepts a write this cycle
pc_o  out  32  fetch PC
flush_o  out  1  kill younger in-flight instructions
busy_o  out  1  init sweep in progress
tbl_we_o  out  1  table write request
tbl_clr_o  out  1  write is a clear (entry zeroed)
tbl_idx_o  out  IDX_W  table index
tbl_jumps_o  out  1  update direction
tbl_branch_pc_o  out  32  update branch PC
tbl_target_pc_o  out  32  update target PC
upd_drop_o  out  1  pulse: update lost, queue full

Behaviour:
- Reset (async, rsn_i low):
  - State INIT, sweep index 0, pc_o=RESET_PC, flush_o=0, busy_o=1, upd_drop_o=0.
  - Queue empty.
  - Reset mid-operation aborts everything and restarts the sweep.
- FSM states: INIT, RUN, REDIR.
- INIT:
  - tbl_we_o=1, tbl_clr_o=1, tbl_idx_o=sweep index, other tbl_* = 0.
  - Index increments only when tbl_ready_i=1.
  - Write of index ENTRIES-1 accepted -> RUN next cycle; busy_o deasserts with the state change.
  - pc_o holds RESET_PC; all alu_* ignored; nothing is queued.
- RUN, next PC priority:
  - (1) alu_valid_i&alu_error_i: pc_o <= alu_jumps_i ? alu_target_pc_i : alu_branch_pc_i+4; go REDIR. Overrides stall_i.
  - (2) stall_i: hold.
  - (3) bp_pred_i&bp_taken_i: pc_o <= bp_pred_pc_i.
  - (4) otherwise pc_o <= pc_o+4.
  - PC arithmetic is mod 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- REDIR (one cycle): flush_o=1 and pc_o holds the corrected PC.
  - New error in REDIR: redirect again, stay REDIR.
  - Otherwise -> RUN.
  - flush_o=0 in all other states.
- Update queue (RUN/REDIR):
  - Push {alu_jumps_i, alu_branch_pc_i, alu_target_pc_i} on every accepted error.
  - Head drives tbl_* combinationally: tbl_we_o=!empty, tbl_clr_o=0, tbl_idx_o=head branch_pc[IDX_W+1:2].
  - Pop when tbl_we_o&tbl_ready_i.
  - Entry pushed at edge N is visible on tbl_* from cycle N+1; there is no bypass.
  - Push+pop in the same cycle is legal at any occupancy; count is unchanged.
  - Push while full with no pop: entry discarded and upd_drop_o=1 for that cycle (registered pulse next cycle is not allowed; drive combinationally). The redirect still happens.
  - Entries are written in FIFO order; pointers wrap modulo QDEPTH.

Test Plan:
- Reset, tbl_ready_i=1 -> 16 clear writes, idx 0..15 on consecutive cycles; busy_o falls on cycle 16; pc_o=0 then 4, 8, 12.
- tbl_ready_i toggling 1/0 during INIT -> each index held until accepted; sweep takes 32 cycles; no duplicate or skipped index.
- RUN: bp_pred_i=1, bp_taken_i=1, bp_pred_pc_i=0x200 -> pc_o=0x200 next cycle; same with stall_i=1 -> pc_o unchanged.
- Error with alu_jumps_i=0, branch_pc=0x104, under stall_i=1 -> pc_o=0x108, flush_o=1 for one cycle; tbl_we_o next cycle with idx=1, jumps=0.
- tbl_ready_i=0, three errors on consecutive cycles, QDEPTH=2 -> third asserts upd_drop_o; after ready, exactly the first two written in order.
- rsn_i pulsed low mid-drain with queue non-empty -> outputs reset immediately; queue cleared; INIT restarts at idx 0.
